ntru_operand_loader: RTL

Input-side front end for the NTRU serial multiplier. It accepts one operand frame over an AXI4-Stream slave: N coefficients of h, then N coefficients of r. It writes them into the h and r coefficient RAMs, counts the non-zero r coefficients (nnz), then clears and launches the multiplier control block and waits for its end_op. It is the writer for the RAMs and the control inputs that the multiplier control reads.

---
 rtl/ntru_operand_loader.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ntru_operand_loader.sv
// Operand front end for the NTRU serial multiplier: loads h and r over AXI4-Stream, counts nnz(r), launches the control block.
// Optional frame-delimiter checking on tlast is compiled in with LOADER_TLAST_CHECK_EN.
module ntru_operand_loader #(
    parameter int N = 541,
    parameter int q = 2048,
    parameter int p = 3,
    localparam int AW = $clog2(N),
    localparam int HW = $clog2(q),
    localparam int RW = $clog2(p),
    localparam int NW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic          h_we,
    output logic [AW-1:0] h_addr,
    output logic [HW-1:0] h_din,
    output logic          r_we,
    output logic [AW-1:0] r_addr,
    output logic [RW-1:0] r_din,
    output logic [NW-1:0] nnz,
    output logic          ctrl_rst_n,
    output logic          start_op,
    input  logic          end_op,
    output logic          done,
    output logic          frame_err
);

    typedef enum logic [2:0] {
        LOAD_H    = 3'd0,
        LOAD_R    = 3'd1,
        START_CLR = 3'd2,
        START     = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] nnz_q, nnz_d;
    logic          tready_q, tready_d;
    logic          h_we_q, h_we_d;
    logic [AW-1:0] h_addr_q, h_addr_d;
    logic [HW-1:0] h_din_q, h_din_d;
    logic          r_we_q, r_we_d;
    logic [AW-1:0] r_addr_q, r_addr_d;
    logic [RW-1:0] r_din_q, r_din_d;
    logic          ctrl_rst_n_q, ctrl_rst_n_d;
    logic          start_op_q, start_op_d;
    logic          done_q, done_d;
    logic          hs;
    logic          last_cnt;
    logic          r_nz;
    logic          unused_inputs;

`ifdef LOADER_TLAST_CHECK_EN
    logic          err_q, err_d;
`endif

    assign hs       = s_axis_tvalid && tready_q;
    assign last_cnt = (cnt_q == AW'(N - 1));
    assign r_nz     = (s_axis_tdata[RW-1:0] != '0);
    // Upper tdata bits (and tlast when unchecked) carry no information.
    assign unused_inputs = ^{s_axis_tdata[31:HW], s_axis_tlast};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nnz_d        = nnz_q;
        tready_d     = 1'b0;
        h_we_d       = 1'b0;
        h_addr_d     = h_addr_q;
        h_din_d      = h_din_q;
        r_we_d       = 1'b0;
        r_addr_d     = r_addr_q;
        r_din_d      = r_din_q;
        ctrl_rst_n_d = 1'b1;
        start_op_d   = 1'b0;
        done_d       = 1'b0;
`ifdef LOADER_TLAST_CHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            LOAD_H: begin
                tready_d = 1'b1;
                if (hs) begin
                    h_we_d   = 1'b1;
                    h_addr_d = cnt_q;
                    h_din_d  = s_axis_tdata[HW-1:0];
                    if (last_cnt) begin
                        cnt_d   = '0;
                        nnz_d   = '0;
                        state_d = LOAD_R;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
`ifdef LOADER_TLAST_CHECK_EN
                    if (cnt_q == '0)
                        err_d = 1'b0;
                    if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = LOAD_H;
                    end
`endif
                end
            end
            LOAD_R: begin
                tready_d = 1'b1;
                if (hs) begin
                    r_we_d   = 1'b1;
                    r_addr_d = cnt_q;
                    r_din_d  = s_axis_tdata[RW-1:0];
                    nnz_d    = nnz_q + NW'(r_nz);
                    if (last_cnt) begin
                        cnt_d        = '0;
                        state_d      = START_CLR;
                        tready_d     = 1'b0;
                        ctrl_rst_n_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
`ifdef LOADER_TLAST_CHECK_EN
                    // A bad delimiter abandons the frame before the launch sequence.
                    if (last_cnt != s_axis_tlast) begin
                        err_d        = 1'b1;
                        cnt_d        = '0;
                        state_d      = LOAD_H;
                        tready_d     = 1'b1;
                        ctrl_rst_n_d = 1'b1;
                    end
`endif
                end
            end
            START_CLR: begin
                state_d    = START;
                start_op_d = 1'b1;
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                if (end_op) begin
                    done_d   = 1'b1;
                    tready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = LOAD_H;
                end
            end
            default: begin
                state_d = LOAD_H;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= LOAD_H;
            cnt_q        <= '0;
            nnz_q        <= '0;
            tready_q     <= 1'b0;
            h_we_q       <= 1'b0;
            h_addr_q     <= '0;
            h_din_q      <= '0;
            r_we_q       <= 1'b0;
            r_addr_q     <= '0;
            r_din_q      <= '0;
            ctrl_rst_n_q <= 1'b1;
            start_op_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_TLAST_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nnz_q        <= nnz_d;
            tready_q     <= tready_d;
            h_we_q       <= h_we_d;
            h_addr_q     <= h_addr_d;
            h_din_q      <= h_din_d;
            r_we_q       <= r_we_d;
            r_addr_q     <= r_addr_d;
            r_din_q      <= r_din_d;
            ctrl_rst_n_q <= ctrl_rst_n_d;
            start_op_q   <= start_op_d;
            done_q       <= done_d;
`ifdef LOADER_TLAST_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign s_axis_tready = tready_q;
    assign h_we          = h_we_q;
    assign h_addr        = h_addr_q;
    assign h_din         = h_din_q;
    assign r_we          = r_we_q;
    assign r_addr        = r_addr_q;
    assign r_din         = r_din_q;
    assign nnz           = nnz_q;
    assign ctrl_rst_n    = ctrl_rst_n_q;
    assign start_op      = start_op_q;
    assign done          = done_q;
`ifdef LOADER_TLAST_CHECK_EN
    assign frame_err     = err_q;
`else
    assign frame_err     = 1'b0;
`endif

endmodule
